data_mem_responder: RTL and testbench

Multi-cycle data-memory responder on the far side of the pipeline's MEM-stage interface. It accepts one read or write request from the MEM stage (`MemRead`/`MemWrite` levels plus address and write data), performs the access after a fixed programmable latency, and drives a combinational `stall` back to the pipeline until it acknowledges. It owns the 8-bit data storage array and replaces the single-cycle data memory behind the EX/MEM pipeline register.

---
 rtl/data_mem_responder.sv | 148 ++++++++++++++
 tb/tb_data_mem_responder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Multi-cycle data-memory responder sitting behind the pipeline's MEM stage.
// A read or write request (MemRead/MemWrite levels) seen in IDLE is captured
// together with its address and store data. The access is performed LATENCY
// cycles later, using only the captured copies. `ack` is then raised for one
// cycle. While the access is outstanding, a combinational `stall` holds the
// pipeline.
//
// Ports:
//   clk        in   1               rising-edge clock
//   rst        in   1               asynchronous, active-high reset
//   MemRead    in   1               read request level
//   MemWrite   in   1               write request level (wins over MemRead)
//   Address    in   ADDRESS_LENGTH  word address
//   WriteData  in   WORD_LENGTH     store data
//   ReadData   out  WORD_LENGTH     registered load data, holds last read
//   ack        out  1               one-cycle completion pulse (registered)
//   stall      out  1               combinational pipeline freeze
//   conflict   out  1               sticky: read and write captured together
//
// LATENCY must lie in 1..15 (4-bit countdown).
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int WORD_LENGTH    = 8,
    parameter int ADDRESS_LENGTH = 8,
    parameter int LATENCY        = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      MemRead,
    input  logic                      MemWrite,
    input  logic [ADDRESS_LENGTH-1:0] Address,
    input  logic [WORD_LENGTH-1:0]    WriteData,
    output logic [WORD_LENGTH-1:0]    ReadData,
    output logic                      ack,
    output logic                      stall,
    output logic                      conflict
);

    localparam int         DEPTH    = 1 << ADDRESS_LENGTH;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ACK
    } state_e;

    state_e                      state_q, state_d;
    logic [3:0]                  cnt_q, cnt_d;
    logic [ADDRESS_LENGTH-1:0]   addr_q;
    logic [WORD_LENGTH-1:0]      wdata_q;
    logic                        wr_q;
    logic [WORD_LENGTH-1:0]      rdata_q;
    logic                        ack_q;
    logic                        conflict_q;
    logic [WORD_LENGTH-1:0]      mem_q [DEPTH];

    logic                        request;
    logic                        capture;
    logic                        complete;

    assign request = MemRead | MemWrite;

    // Next-state logic. The edge that leaves ACK never captures, because the
    // request levels at that edge still belong to the retiring instruction.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d  = state_q;
        cnt_d    = cnt_q;
        capture  = 1'b0;
        complete = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (request) begin
                    capture = 1'b1;
                    cnt_d   = CNT_LOAD;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    complete = 1'b1;
                    state_d  = ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and data registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is updated with non-blocking assignments so that every register samples pre-edge values.
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_q       <= 1'b0;
            rdata_q    <= '0;
            ack_q      <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= complete;
            if (capture) begin
                addr_q  <= Address;
                wdata_q <= WriteData;
                wr_q    <= MemWrite;
                if (MemRead && MemWrite) begin
                    conflict_q <= 1'b1;
                end
            end
            if (complete && !wr_q) begin
                rdata_q <= mem_q[addr_q];
            end
        end
    end

    // Storage array. An access in flight when reset arrives never reaches
    // the array: the write only happens on the non-reset branch.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the array is reset because the design must read 0 from every word after reset; this makes it flops, not a RAM macro.
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (complete && wr_q) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign stall    = request && (state_q != ACK);
    assign ReadData = rdata_q;
    assign ack      = ack_q;
    assign conflict = conflict_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//
// Four responder instances share one clock and one reset. They use
// LATENCY = 2, 1, 15 and 3. Each access pushes the expected ReadData and
// conflict value into a scoreboard queue. The entry is popped and compared
// when the DUT raises ack. ack latency, stall width and ack spacing are
// checked against the latency of the instance.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

    localparam int N = 4;

    typedef struct {
        int         idx;
        logic [7:0] rdata;
        logic       conf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       mr       [N];
    logic       mw       [N];
    logic [7:0] addr     [N];
    logic [7:0] wd       [N];
    logic [7:0] rd       [N];
    logic       ack      [N];
    logic       stall    [N];
    logic       conflict [N];

    logic [7:0] model_mem  [N][256];
    logic [7:0] model_rd   [N];
    logic       model_conf [N];
    exp_t       sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ack_cnt  [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 15 : 3;
        data_mem_responder #(
            .WORD_LENGTH   (8),
            .ADDRESS_LENGTH(8),
            .LATENCY       (LAT)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .MemRead  (mr[g]),
            .MemWrite (mw[g]),
            .Address  (addr[g]),
            .WriteData(wd[g]),
            .ReadData (rd[g]),
            .ack      (ack[g]),
            .stall    (stall[g]),
            .conflict (conflict[g])
        );
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (ack[i]) ack_cnt[i]++;
        end
    end

    function automatic int lat_of(input int i);
        case (i)
            0:       return 2;
            1:       return 1;
            2:       return 15;
            default: return 3;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < N; i++) begin
            for (int a = 0; a < 256; a++) model_mem[i][a] = 8'h00;
            model_rd[i]   = 8'h00;
            model_conf[i] = 1'b0;
        end
    endtask

    // Drive one request on instance i and follow it to completion. With
    // hold set, the request levels are left asserted after the ACK->IDLE
    // edge, as a pipeline that has not yet presented the next instruction
    // would leave them.
    task automatic access(input int i, input logic rd_en, input logic wr_en,
                          input logic [7:0] a, input logic [7:0] d,
                          input logic hold, output int ack_cyc);
        exp_t e;
        int   st_cnt;
        bit   got;
        mr[i]   = rd_en;
        mw[i]   = wr_en;
        addr[i] = a;
        wd[i]   = d;
        if (wr_en) model_mem[i][a] = d;
        else       model_rd[i]     = model_mem[i][a];
        if (rd_en && wr_en) model_conf[i] = 1'b1;
        e.idx   = i;
        e.rdata = model_rd[i];
        e.conf  = model_conf[i];
        sb_q.push_back(e);
        ack_cyc = -1;
        #1;
        check("stall_on_request", 32'(stall[i]), 32'd1);
        st_cnt = stall[i] ? 1 : 0;
        got    = 1'b0;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(posedge clk);
            #1;
            if (ack[i]) begin
                got     = 1'b1;
                ack_cyc = cyc;
                e       = sb_q.pop_front();
                check("ack_latency", 32'(c - 1), 32'(lat_of(i)));
                check("stall_low_in_ack", 32'(stall[i]), 32'd0);
                check("stall_width", 32'(st_cnt), 32'(lat_of(i) + 1));
                check("read_data", 32'(rd[i]), 32'(e.rdata));
                check("conflict_flag", 32'(conflict[i]), 32'(e.conf));
            end else if (stall[i]) begin
                st_cnt++;
            end
        end
        if (!got) begin
            check("ack_timeout", 32'd0, 32'd1);
            e = sb_q.pop_front();
        end
        @(posedge clk);
        #1;
        check("ack_one_cycle", 32'(ack[i]), 32'd0);
        if (!hold) begin
            mr[i] = 1'b0;
            mw[i] = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t1, t2, t3, a0, a3;
        for (int i = 0; i < N; i++) begin
            mr[i] = 1'b0; mw[i] = 1'b0; addr[i] = 8'h00; wd[i] = 8'h00;
        end
        reset_model();
        rst = 1'b1;
        #3;
        for (int i = 0; i < N; i++) begin
            check("reset_readdata", 32'(rd[i]), 32'd0);
            check("reset_ack", 32'(ack[i]), 32'd0);
            check("reset_conflict", 32'(conflict[i]), 32'd0);
            check("reset_stall", 32'(stall[i]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Read of a freshly reset word, then write/read of 0x3C.
        access(0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, t1);
        access(0, 1'b0, 1'b1, 8'h3C, 8'hA5, 1'b0, t1);
        access(0, 1'b1, 1'b0, 8'h3C, 8'h00, 1'b0, t1);
        check("wr_then_rd_3c", 32'(rd[0]), 32'hA5);

        // Latency sweep on the LATENCY=1 and LATENCY=15 instances.
        for (int i = 1; i <= 2; i++) begin
            access(i, 1'b0, 1'b1, 8'h10, 8'h5A, 1'b0, t1);
            access(i, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, t1);
        end

        // Back-to-back with request levels held continuously.
        a0 = ack_cnt[0];
        access(0, 1'b0, 1'b1, 8'h01, 8'h11, 1'b1, t1);
        access(0, 1'b0, 1'b1, 8'h02, 8'h22, 1'b1, t2);
        access(0, 1'b1, 1'b0, 8'h01, 8'h00, 1'b0, t3);
        check("b2b_spacing_1", 32'(t2 - t1), 32'd4);
        check("b2b_spacing_2", 32'(t3 - t2), 32'd4);
        repeat (8) @(negedge clk);
        check("b2b_ack_count", 32'(ack_cnt[0] - a0), 32'd3);
        check("b2b_final_read", 32'(rd[0]), 32'h11);

        // Simultaneous read and write: write wins, conflict sticks.
        access(0, 1'b1, 1'b1, 8'h7F, 8'hC3, 1'b0, t1);
        access(0, 1'b1, 1'b0, 8'h7F, 8'h00, 1'b0, t1);
        check("conflict_sticky", 32'(conflict[0]), 32'd1);

        // Asynchronous reset in mid-cycle clears outputs immediately.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < N; i++) begin
            check("async_rst_readdata", 32'(rd[i]), 32'd0);
            check("async_rst_ack", 32'(ack[i]), 32'd0);
            check("async_rst_conflict", 32'(conflict[i]), 32'd0);
        end
        reset_model();
        @(negedge clk);
        rst = 1'b0;
        access(0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, t1);
        access(0, 1'b1, 1'b0, 8'h3C, 8'h00, 1'b0, t1);

        // Reset held across what would have been the BUSY->ACK edge.
        a3 = ack_cnt[3];
        @(negedge clk);
        mw[3] = 1'b1; addr[3] = 8'h20; wd[3] = 8'hFF;
        @(posedge clk);
        #1;
        check("midbusy_stall", 32'(stall[3]), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst   = 1'b1;
        mw[3] = 1'b0;
        reset_model();
        @(negedge clk);
        rst = 1'b0;
        check("midbusy_no_ack", 32'(ack_cnt[3] - a3), 32'd0);
        check("midbusy_ack_low", 32'(ack[3]), 32'd0);
        check("midbusy_stall_low", 32'(stall[3]), 32'd0);
        access(3, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0, t1);
        check("midbusy_no_write", 32'(rd[3]), 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
